// File: rtl/core_inst_sequencer.sv
// Autonomous 34-bit instruction generator for core: per-kernel-position weight/activation
// load, execute and psum drain, followed by an output-pixel accumulation pass.
module core_inst_sequencer #(
    parameter int unsigned ROW       = 8,
    parameter int unsigned COL       = 8,
    parameter int unsigned LEN_KIJ   = 9,
    parameter int unsigned KER_W     = 3,
    parameter int unsigned IN_W      = 6,
    parameter int unsigned LEN_ONIJ  = 16,
    parameter int unsigned W_BASE    = 64,
    parameter int unsigned LOAD_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij_o
);

    localparam int unsigned LEN_NIJ = IN_W * IN_W;
    localparam int unsigned OUT_W   = IN_W - KER_W + 1;
    localparam int unsigned CNT_W   = 7;
    localparam int unsigned O_W     = 5;
    localparam int unsigned A_W     = 11;

    typedef struct packed {
        logic           acc;
        logic           cen_p;
        logic           wen_p;
        logic [A_W-1:0] a_p;
        logic           cen_x;
        logic           wen_x;
        logic [A_W-1:0] a_x;
        logic           ofifo_rd;
        logic           ififo_wr;
        logic           ififo_rd;
        logic           l0_rd;
        logic           l0_wr;
        logic           execute;
        logic           load;
    } inst_t;

    typedef enum logic [2:0] {
        S_IDLE, S_W_XFER, S_W_LOAD, S_X_XFER, S_X_EXEC, S_DRAIN, S_ACC, S_DONE
    } state_t;

    localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [O_W-1:0]    o_cnt, o_n;
    logic [3:0]        kij, kij_n;
    logic              busy_n, done_n;
    logic [A_W-1:0]    acc_addr;
    inst_t             w;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            o_cnt <= '0;
            kij   <= '0;
            inst  <= IDLE_INST;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            o_cnt <= o_n;
            kij   <= kij_n;
            inst  <= w;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    assign kij_o = kij;

    // Output pixel o = (row, col) reads psum of kernel tap k at the shifted input pixel.
    always_comb begin
        acc_addr = A_W'(cnt) * A_W'(LEN_NIJ)
                 + (A_W'(o_cnt) / A_W'(OUT_W) + A_W'(cnt) / A_W'(KER_W)) * A_W'(IN_W)
                 + A_W'(o_cnt) % A_W'(OUT_W) + A_W'(cnt) % A_W'(KER_W);
    end

    // Next state/counters and the instruction word emitted after the coming edge.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        o_n     = o_cnt;
        kij_n   = kij;
        busy_n  = busy;
        done_n  = 1'b0;
        w       = IDLE_INST;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_W_XFER;
                    cnt_n   = '0;
                    o_n     = '0;
                    kij_n   = '0;
                    busy_n  = 1'b1;
                end
            end
            S_W_XFER: begin
                if (cnt < CNT_W'(ROW)) begin
                    w.cen_x = 1'b0;
                    w.wen_x = 1'b1;
                    w.a_x   = A_W'(W_BASE) + A_W'(kij) * A_W'(ROW) + A_W'(cnt);
                end
                w.l0_wr = (cnt != '0);
                if (cnt == CNT_W'(ROW)) begin
                    state_n = S_W_LOAD;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_W_LOAD: begin
                if (cnt < CNT_W'(COL)) begin
                    w.l0_rd = 1'b1;
                    w.load  = 1'b1;
                end
                if (cnt == CNT_W'(COL + LOAD_WAIT - 1)) begin
                    state_n = S_X_XFER;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_X_XFER: begin
                if (cnt < CNT_W'(LEN_NIJ)) begin
                    w.cen_x = 1'b0;
                    w.wen_x = 1'b1;
                    w.a_x   = A_W'(cnt);
                end
                w.l0_wr = (cnt != '0);
                if (cnt == CNT_W'(LEN_NIJ)) begin
                    state_n = S_X_EXEC;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_X_EXEC: begin
                w.l0_rd   = 1'b1;
                w.execute = 1'b1;
                if (cnt == CNT_W'(LEN_NIJ - 1)) begin
                    state_n = S_DRAIN;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt == CNT_W'(LEN_NIJ)) begin
                    cnt_n = '0;
                    if (kij == 4'(LEN_KIJ - 1)) begin
                        state_n = S_ACC;
                        o_n     = '0;
                    end else begin
                        state_n = S_W_XFER;
                        kij_n   = kij + 4'd1;
                    end
                end else if (ofifo_valid) begin
                    w.ofifo_rd = 1'b1;
                    w.cen_p    = 1'b0;
                    w.wen_p    = 1'b0;
                    w.a_p      = A_W'(kij) * A_W'(LEN_NIJ) + A_W'(cnt);
                    cnt_n      = cnt + CNT_W'(1);
                end
            end
            S_ACC: begin
                if (cnt < CNT_W'(LEN_KIJ)) begin
                    w.acc   = 1'b1;
                    w.cen_p = 1'b0;
                    w.wen_p = 1'b1;
                    w.a_p   = acc_addr;
                    cnt_n   = cnt + CNT_W'(1);
                end else begin
                    cnt_n = '0;
                    if (o_cnt == O_W'(LEN_ONIJ - 1)) begin
                        state_n = S_DONE;
                    end else begin
                        o_n = o_cnt + O_W'(1);
                    end
                end
            end
            S_DONE: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Directed self-checking bench for core_inst_sequencer: records the emitted instruction
// stream of one full run and compares it with hand-computed addresses and counts.
module tb_core_inst_sequencer;

    localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  kij_o;

    core_inst_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done),
        .kij_o       (kij_o)
    );

    always #5 clk = ~clk;

    logic        acc_b, cen_p, wen_p, cen_x, wen_x, ofifo_rd, l0_rd, l0_wr, exe, load;
    logic [10:0] a_p, a_x;
    assign acc_b    = inst[33];
    assign cen_p    = inst[32];
    assign wen_p    = inst[31];
    assign a_p      = inst[30:20];
    assign cen_x    = inst[19];
    assign wen_x    = inst[18];
    assign a_x      = inst[17:7];
    assign ofifo_rd = inst[6];
    assign l0_rd    = inst[3];
    assign l0_wr    = inst[2];
    assign exe      = inst[1];
    assign load     = inst[0];

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stream recorder; ofifo_valid toggles every cycle and is read before it changes.
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   xcyc[$], xaddr[$], l0wr_cyc[$], load_cyc[$], pw2[$], acc_addr[$];
    int   rd_kij[9];
    int   rd_total = 0, rd_bad = 0, pw2_bad = 0, gaps = 0, done_cnt = 0;
    logic busy_at_done = 1'b1, busy_before_done = 1'b0, prev_acc = 1'b0, prev_busy = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (mon_en) begin
            if (!cen_x && wen_x) begin
                xaddr.push_back(int'(a_x));
                xcyc.push_back(cyc);
            end
            if (l0_wr) l0wr_cyc.push_back(cyc);
            if (load && l0_rd) load_cyc.push_back(cyc);
            if (ofifo_rd) begin
                rd_total++;
                if (kij_o < 4'd9) rd_kij[kij_o]++;
                if (!ofifo_valid) rd_bad++;
                if (kij_o == 4'd2) begin
                    pw2.push_back(int'(a_p));
                    if (cen_p !== 1'b0 || wen_p !== 1'b0) pw2_bad++;
                end
            end
            if (acc_b) acc_addr.push_back(int'(a_p));
            if (prev_acc && !acc_b) gaps++;
            prev_acc = acc_b;
            if (done) begin
                done_cnt++;
                busy_at_done     = busy;
                busy_before_done = prev_busy;
            end
            prev_busy = busy;
        end
        ofifo_valid = ~ofifo_valid;
    end

    int acc_o0[9] = '{0, 37, 74, 114, 151, 188, 228, 265, 302};

    initial begin
        bit seen;
        reset       = 1'b1;
        start       = 1'b0;
        ofifo_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("reset_state", {30'd0, inst, busy, done}, {30'd0, IDLE_INST, 1'b0, 1'b0});
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_val("idle_after_reset", {31'd0, inst, busy}, {31'd0, IDLE_INST, 1'b0});

        mon_en = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("busy_after_start", busy, 1);

        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_val("run_done_seen", seen, 1);
        repeat (3) @(negedge clk);
        mon_en = 1'b0;

        check_val("xmem_read_count", xaddr.size(), 9 * (8 + 36));
        check_val("load_count", load_cyc.size(), 72);
        if (xaddr.size() >= 45 && load_cyc.size() >= 9 && l0wr_cyc.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                check_val("w_xfer_addr", xaddr[i], 64 + i);
                check_val("w_xfer_cycle", xcyc[i] - xcyc[0], i);
                check_val("w_l0_wr_lag", l0wr_cyc[i] - xcyc[0], i + 1);
            end
            check_val("load_start", load_cyc[0] - xcyc[0], 9);
            check_val("load_run_len", load_cyc[7] - load_cyc[0], 7);
            check_val("x_xfer_first_addr", xaddr[8], 0);
            check_val("x_xfer_after_wait", xcyc[8] - load_cyc[7], 17);
            check_val("kij1_weight_addr", xaddr[44], 72);
        end

        check_val("ofifo_rd_total", rd_total, 324);
        for (int k = 0; k < 9; k++) check_val("ofifo_rd_per_kij", rd_kij[k], 36);
        check_val("ofifo_rd_while_invalid", rd_bad, 0);

        check_val("kij2_write_count", pw2.size(), 36);
        if (pw2.size() == 36)
            for (int i = 0; i < 36; i++) check_val("kij2_pmem_addr", pw2[i], 72 + i);
        check_val("kij2_write_enable", pw2_bad, 0);

        check_val("acc_count", acc_addr.size(), 144);
        if (acc_addr.size() == 144) begin
            for (int k = 0; k < 9; k++) check_val("acc_o0_addr", acc_addr[k], acc_o0[k]);
            check_val("acc_o5_k0_addr", acc_addr[45], 7);
            check_val("acc_o15_k8_addr", acc_addr[143], 323);
        end
        check_val("acc_idle_gaps", gaps, 16);
        check_val("done_pulses", done_cnt, 1);
        check_val("busy_low_at_done", busy_at_done, 0);
        check_val("busy_high_before_done", busy_before_done, 1);

        // Second run, aborted by reset in the middle of kij=4 execute.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (kij_o == 4'd4 && exe) seen = 1'b1;
        end
        check_val("reached_kij4_exec", seen, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("abort_inst_idle", inst, IDLE_INST);
        check_val("abort_kij_zero", kij_o, 0);
        check_val("abort_busy_low", {busy, done}, 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check_val("abort_no_done", seen, 0);

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (!cen_x) seen = 1'b1;
        end
        check_val("restart_read_seen", seen, 1);
        check_val("restart_first_addr", a_x, 64);
        check_val("restart_kij", kij_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
